// File: rtl/child_queue_motion.sv
// -----------------------------------------------------------------------------
// child_queue_motion
//
// Per-child motion sequencer for the shop queue (one instance per child).
// Walks a child from START_X left toward the counter, serves it there for
// SERVE_FRAMES frame ticks, then walks it off the left edge and returns to
// idle. The child's X position and keycode feed back into the queue spacing
// checker, which answers with child_stop when the child ahead is too close.
//
// Optional feature (macro CHILD_PATIENCE_EN): a child blocked for
// PATIENCE_FRAMES consecutive ticks gives up, skips the counter, walks off
// from where it stands and raises 'angry' until its next spawn. Without the
// macro a blocked child waits indefinitely and 'angry' is tied low.
//
// Ports:
//   Clk        in   system clock
//   Reset      in   synchronous, active-high reset
//   frame_clk  in   vsync-derived frame clock, sampled in the Clk domain
//   spawn      in   one-cycle request to start a child (honoured in IDLE only)
//   child_stop in   blocked by the child ahead
//   child_X    out  [9:0] current X position (registered)
//   keycode    out  [7:0] 8'h04 while walking left, else 8'h00 (decoded)
//   active     out  child is on screen (decoded)
//   serving    out  child is at the counter (decoded)
//   done       out  one-cycle pulse when the child despawns (registered)
//   angry      out  child left through the patience timeout (registered)
// -----------------------------------------------------------------------------
module child_queue_motion #(
    parameter logic [9:0] START_X         = 10'd600,
    parameter logic [9:0] COUNTER_X       = 10'd120,
    parameter logic [9:0] STEP            = 10'd1,
    parameter logic [7:0] SERVE_FRAMES    = 8'd120,
    parameter logic [9:0] PATIENCE_FRAMES = 10'd600
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       spawn,
    input  logic       child_stop,
    output logic [9:0] child_X,
    output logic [7:0] keycode,
    output logic       active,
    output logic       serving,
    output logic       done,
    output logic       angry
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WALK    = 3'd1;
    localparam logic [2:0] BLOCKED = 3'd2;
    localparam logic [2:0] SERVE   = 3'd3;
    localparam logic [2:0] EXIT    = 3'd4;

    // child_X - STEP <= COUNTER_X rewritten as child_X <= COUNTER_X + STEP,
    // evaluated one bit wider so neither side can wrap.
    localparam logic [10:0] WALK_LIMIT = {1'b0, COUNTER_X} + {1'b0, STEP};

    logic [2:0] state;
    logic       frame_q;
    logic       tick;
    logic [7:0] serve_cnt;
    logic       reach_counter;
    logic       leave_screen;
    logic       patience_out;

    // One Clk cycle per rising edge of the frame clock.
    assign tick          = frame_clk & ~frame_q;
    assign reach_counter = ({1'b0, child_X} <= WALK_LIMIT);
    assign leave_screen  = (child_X <= STEP);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; the reset is synchronous, so it lives inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            child_X   <= START_X;
            done      <= 1'b0;
            serve_cnt <= 8'd0;
            frame_q   <= 1'b0;
        end else begin
            frame_q <= frame_clk;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    child_X <= START_X;
                    if (spawn) state <= WALK;
                end
                WALK: begin
                    if (tick) begin
                        if (child_stop) begin
                            state <= BLOCKED;
                        end else if (reach_counter) begin
                            child_X   <= COUNTER_X;
                            serve_cnt <= 8'd0;
                            state     <= SERVE;
                        end else begin
                            child_X <= child_X - STEP;
                        end
                    end
                end
                BLOCKED: begin
                    // Leaving BLOCKED costs one frame without motion.
                    if (tick) begin
                        if (!child_stop)       state <= WALK;
                        else if (patience_out) state <= EXIT;
                    end
                end
                SERVE: begin
                    if (tick) begin
                        if (serve_cnt == SERVE_FRAMES - 8'd1) state <= EXIT;
                        else serve_cnt <= serve_cnt + 8'd1;
                    end
                end
                EXIT: begin
                    if (tick) begin
                        if (leave_screen) begin
                            child_X <= START_X;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            child_X <= child_X - STEP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CHILD_PATIENCE_EN
    logic [9:0] wait_cnt;

    assign patience_out = (wait_cnt == PATIENCE_FRAMES - 10'd1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_cnt <= 10'd0;
            angry    <= 1'b0;
        end else begin
            if (state == IDLE && spawn) angry <= 1'b0;
            if (state == BLOCKED) begin
                if (tick) begin
                    if (!child_stop) begin
                        wait_cnt <= 10'd0;
                    end else if (patience_out) begin
                        wait_cnt <= 10'd0;
                        angry    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
            end else begin
                wait_cnt <= 10'd0;
            end
        end
    end
`else
    logic unused_patience;

    assign unused_patience = |PATIENCE_FRAMES;
    assign patience_out    = 1'b0;
    assign angry           = 1'b0;
`endif

    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        keycode = 8'h00;
        if (state == WALK || state == EXIT) keycode = 8'h04;
    end

    assign active  = (state != IDLE);
    assign serving = (state == SERVE);

endmodule

// File: tb/tb_child_queue_motion.sv
// -----------------------------------------------------------------------------
// tb_child_queue_motion
//
// Self-checking bench for child_queue_motion (default parameters). A
// behavioural model of the child's journey runs alongside the DUT and is
// compared every cycle; a table of short vectors and hand-written sequences
// pin down the reset, walk, block, serve, exit and despawn behaviour.
// Define CHILD_PATIENCE_EN for both bench and design to cover the timeout.
// -----------------------------------------------------------------------------
module tb_child_queue_motion;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       spawn = 1'b0;
    logic       child_stop = 1'b0;
    logic [9:0] child_X;
    logic [7:0] keycode;
    logic       active;
    logic       serving;
    logic       done;
    logic       angry;

    int n_vec = 0;
    int n_bad = 0;

    child_queue_motion dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .spawn      (spawn),
        .child_stop (child_stop),
        .child_X    (child_X),
        .keycode    (keycode),
        .active     (active),
        .serving    (serving),
        .done       (done),
        .angry      (angry)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // ---------------------------------------------------------------------
    // Output vector helpers: {X, keycode, active, serving, done, angry}
    // ---------------------------------------------------------------------
    function automatic logic [21:0] pack(input logic [9:0] x, input logic [7:0] k,
                                         input logic a, input logic s,
                                         input logic d, input logic g);
        return {x, k, a, s, d, g};
    endfunction

    function automatic logic [21:0] outs();
        return {child_X, keycode, active, serving, done, angry};
    endfunction

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got X=%0d key=%0h act=%0b srv=%0b done=%0b angry=%0b, required X=%0d key=%0h act=%0b srv=%0b done=%0b angry=%0b",
                     name, act[21:12], act[11:4], act[3], act[2], act[1], act[0],
                     exp[21:12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: where the child is in its journey, in plain ints.
    // ---------------------------------------------------------------------
    typedef enum int {M_IDLE, M_WALK, M_BLOCKED, M_SERVE, M_EXIT} phase_t;

    phase_t m_phase  = M_IDLE;
    int     m_x      = 600;
    int     m_served = 0;
    bit     m_done   = 1'b0;
    bit     m_angry  = 1'b0;
    bit     m_prev   = 1'b0;
`ifdef CHILD_PATIENCE_EN
    int     m_waited = 0;
`endif

    task automatic model_edge();
        bit t;
        if (Reset) begin
            m_phase = M_IDLE;
            m_x     = 600;
            m_done  = 1'b0;
            m_angry = 1'b0;
            m_prev  = 1'b0;
            return;
        end
        t      = frame_clk && !m_prev;
        m_prev = frame_clk;
        m_done = 1'b0;
        case (m_phase)
            M_IDLE: begin
                m_x = 600;
                if (spawn) begin
                    m_phase = M_WALK;
                    m_angry = 1'b0;
                end
            end
            M_WALK: if (t) begin
                if (child_stop) begin
                    m_phase = M_BLOCKED;
`ifdef CHILD_PATIENCE_EN
                    m_waited = 0;
`endif
                end else if (m_x - 1 <= 120) begin
                    m_x      = 120;
                    m_served = 0;
                    m_phase  = M_SERVE;
                end else begin
                    m_x = m_x - 1;
                end
            end
            M_BLOCKED: if (t) begin
                if (!child_stop) begin
                    m_phase = M_WALK;
                end else begin
`ifdef CHILD_PATIENCE_EN
                    m_waited = m_waited + 1;
                    if (m_waited == 600) begin
                        m_phase = M_EXIT;
                        m_angry = 1'b1;
                    end
`endif
                end
            end
            M_SERVE: if (t) begin
                m_served = m_served + 1;
                if (m_served == 120) m_phase = M_EXIT;
            end
            M_EXIT: if (t) begin
                if (m_x <= 1) begin
                    m_x     = 600;
                    m_done  = 1'b1;
                    m_phase = M_IDLE;
                end else begin
                    m_x = m_x - 1;
                end
            end
            default: m_phase = M_IDLE;
        endcase
    endtask

    function automatic logic [21:0] model_out();
        logic [7:0] k;
        k = (m_phase == M_WALK || m_phase == M_EXIT) ? 8'h04 : 8'h00;
        return pack(10'(m_x), k, m_phase != M_IDLE, m_phase == M_SERVE, m_done, m_angry);
    endfunction

    // One clock: inputs are already stable; model and DUT advance together,
    // outputs are compared 1 ns after the edge.
    task automatic cycle();
        @(posedge Clk);
        model_edge();
        #1;
        check("model", outs(), model_out());
    endtask

    task automatic do_tick();
        frame_clk = 1'b1;
        cycle();
        frame_clk = 1'b0;
        cycle();
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic do_spawn();
        spawn = 1'b1;
        cycle();
        spawn = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Vector table: one clock per record
    // ---------------------------------------------------------------------
    typedef struct {
        logic       rst;
        logic       fc;
        logic       sp;
        logic       st;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, pack(10'd600, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, pack(10'd600, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, pack(10'd600, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, pack(10'd599, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, pack(10'd599, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, pack(10'd599, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, pack(10'd599, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, pack(10'd599, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, pack(10'd599, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, pack(10'd599, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, pack(10'd598, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, pack(10'd598, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, pack(10'd600, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)};

        for (int i = 0; i < 13; i++) begin
            Reset      = tbl[i].rst;
            frame_clk  = tbl[i].fc;
            spawn      = tbl[i].sp;
            child_stop = tbl[i].st;
            cycle();
            check($sformatf("tbl[%0d]", i), outs(), tbl[i].exp);
        end
        Reset = 1'b0;
        frame_clk = 1'b0;
        spawn = 1'b0;
        child_stop = 1'b0;

        // --- Full journey: walk 600->120, serve 120 ticks, exit, despawn ---
        do_reset();
        do_spawn();
        check("spawn_walk", outs(), pack(10'd600, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
        do_ticks(479);
        check("walk_121", outs(), pack(10'd121, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
        do_tick();
        check("reach_counter", outs(), pack(10'd120, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
        do_ticks(119);
        check("serve_119", outs(), pack(10'd120, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
        do_tick();
        check("serve_to_exit", outs(), pack(10'd120, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
        do_ticks(119);
        check("exit_x1", outs(), pack(10'd1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
        frame_clk = 1'b1;
        cycle();
        check("despawn_pulse", outs(), pack(10'd600, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
        frame_clk = 1'b0;
        cycle();
        check("despawn_after", outs(), pack(10'd600, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));

        // --- Block at X=300 for 10 ticks, release costs one idle frame ---
        do_spawn();
        do_ticks(300);
        check("walk_300", outs(), pack(10'd300, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
        child_stop = 1'b1;
        do_ticks(10);
        check("blocked_300", outs(), pack(10'd300, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        child_stop = 1'b0;
        do_tick();
        check("release_hold", outs(), pack(10'd300, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
        do_tick();
        check("release_step", outs(), pack(10'd299, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));

        // --- frame_clk held high: one step only; spawn in WALK ignored ---
        frame_clk = 1'b1;
        for (int i = 0; i < 1000; i++) cycle();
        check("fc_held_high", outs(), pack(10'd298, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
        frame_clk = 1'b0;
        cycle();
        do_spawn();
        check("spawn_in_walk", outs(), pack(10'd298, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
        do_tick();
        check("walk_after_spawn", outs(), pack(10'd297, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));

        // --- Reset in SERVE, with spawn asserted alongside ---
        do_ticks(177);
        check("serve_again", outs(), pack(10'd120, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
        do_ticks(5);
        Reset = 1'b1;
        spawn = 1'b1;
        cycle();
        check("reset_in_serve", outs(), pack(10'd600, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        Reset = 1'b0;
        spawn = 1'b0;
        cycle();
        check("idle_after_reset", outs(), pack(10'd600, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));

        // --- Reset in EXIT at X=50 ---
        do_spawn();
        do_ticks(480 + 120 + 70);
        check("exit_x50", outs(), pack(10'd50, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
        do_reset();
        check("reset_in_exit", outs(), pack(10'd600, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));

        // --- Long block at X=200 ---
        do_spawn();
        do_ticks(400);
        check("walk_200", outs(), pack(10'd200, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
        child_stop = 1'b1;
        do_ticks(610);
`ifdef CHILD_PATIENCE_EN
        check("patience_exit", outs(), pack(10'd191, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1));
        child_stop = 1'b0;
        do_ticks(190);
        check("angry_exit_x1", outs(), pack(10'd1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1));
        frame_clk = 1'b1;
        cycle();
        check("angry_despawn", outs(), pack(10'd600, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1));
        frame_clk = 1'b0;
        cycle();
        do_spawn();
        check("spawn_clears_angry", outs(), pack(10'd600, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
`else
        check("still_blocked", outs(), pack(10'd200, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        child_stop = 1'b0;
        do_tick();
        check("late_release_hold", outs(), pack(10'd200, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
        do_tick();
        check("late_release_step", outs(), pack(10'd199, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
`endif
        do_reset();

        // --- Randomised traffic against the model ---
        for (int i = 0; i < 20000; i++) begin
            Reset      = ($urandom_range(0, 2999) == 0);
            spawn      = ($urandom_range(0, 19) == 0);
            child_stop = ($urandom_range(0, 3) == 0);
            frame_clk  = $urandom_range(0, 1) == 1;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
